// File: rtl/isa_types.sv
// Shared types for the hart sequencer: pipeline stage encoding, halt-cause
// codes and the major opcode field of the instruction being executed.
package isa_types;

  // Sequencer state, also exported on the debug stage port.
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } stage_t;

  // Halt cause reported on the fault port.
  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_BUS     = 2'd2;

  // Major opcode field (instr[6:0]) as produced by the instruction decoder.
  // Values outside this list reach the sequencer unchanged and are illegal.
  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    OP_IMM = 7'b0010011,
    AUIPC  = 7'b0010111,
    STORE  = 7'b0100011,
    OP     = 7'b0110011,
    LUI    = 7'b0110111,
    BRANCH = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111
  } opcode_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the shared memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (takes priority over busy)
//   busy       : a request is outstanding and was not acknowledged this cycle
//   timeout    : the registered count has reached LIMIT
module mem_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic timeout
);

  // One spare code: the count may step once past LIMIT on the cycle the
  // sequencer leaves for HALT, and must not wrap back into range.
  localparam int unsigned W = $clog2(LIMIT + 2);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (busy) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign timeout = (count_q == W'(LIMIT));

endmodule

// File: rtl/hart_sequencer.sv
// Multi-cycle control sequencer for a single-ported RISC-V style hart.
// Walks FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] and emits the
// datapath strobes as decodes of the current stage, opcode and mem_ack.
//   clk, rst_n     : clock, asynchronous active-low reset
//   opcode         : major opcode of the latched instruction
//   mem_req/we/sel : shared memory port request, write strobe, address mux
//   mem_ack        : one-cycle memory completion pulse
//   ir_load        : capture read data into the instruction register
//   rf_we, pc_we   : register file and PC write enables
//   stage          : current stage (debug)
//   halted, fault  : sticky halt flag and its cause
//   instret        : 64-bit retired-instruction counter
module hart_sequencer
  import isa_types::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  opcode_t     opcode,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic        rf_we,
  output logic        pc_we,
  output stage_t      stage,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [63:0] instret
);

  stage_t      stage_q, stage_d;
  logic [1:0]  fault_q, fault_d;
  logic [63:0] instret_q;
  // Low during reset and for the first cycle after it, so mem_req only rises
  // on the first clock edge after rst_n deasserts and drops the moment reset
  // asserts.
  logic        active_q;
  logic        wait_expired;
  logic        timer_clear;
  logic        timer_busy;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .busy    (timer_busy),
    .timeout (wait_expired)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    fault_d = fault_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    ir_load = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;

    if (active_q) begin
      case (stage_q)
        FETCH: begin
          mem_req = 1'b1;
          // An ack in the same cycle the count hits the limit still wins.
          if (mem_ack) begin
            ir_load = 1'b1;
            stage_d = DECODE;
          end else if (wait_expired) begin
            stage_d = HALT;
            fault_d = FAULT_BUS;
          end
        end

        DECODE: stage_d = EXECUTE;

        EXECUTE: begin
          case (opcode)
            LOAD, STORE:                     stage_d = MEM;
            OP, OP_IMM, LUI, AUIPC, JAL, JALR: stage_d = WRITEBACK;
            BRANCH: begin
              pc_we   = 1'b1;
              stage_d = FETCH;
            end
            default: begin
              stage_d = HALT;
              fault_d = FAULT_ILLEGAL;
            end
          endcase
        end

        MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (opcode == STORE);
          if (mem_ack) begin
            if (opcode == STORE) begin
              pc_we   = 1'b1;
              stage_d = FETCH;
            end else begin
              stage_d = WRITEBACK;
            end
          end else if (wait_expired) begin
            stage_d = HALT;
            fault_d = FAULT_BUS;
          end
        end

        WRITEBACK: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          stage_d = FETCH;
        end

        HALT: stage_d = HALT;

        default: stage_d = HALT;
      endcase
    end
  end

  // Acks are only meaningful while a request is outstanding; elsewhere they
  // neither clear nor advance the wait counter.
  assign timer_clear = (mem_req && mem_ack) ||
                       (((stage_d == FETCH) || (stage_d == MEM)) && (stage_d != stage_q));
  assign timer_busy  = mem_req && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= FETCH;
      fault_q   <= FAULT_NONE;
      instret_q <= '0;
      active_q  <= 1'b0;
    end else begin
      active_q <= 1'b1;
      stage_q  <= stage_d;
      fault_q  <= fault_d;
      // pc_we is never raised in HALT, so this counts retirements only.
      if (pc_we) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign stage   = stage_q;
  assign halted  = (stage_q == HALT);
  assign fault   = fault_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_hart_sequencer.sv
// Self-checking bench for hart_sequencer. The bench acts as the memory: for
// each instruction it derives, from the opcode class and the chosen ack
// delays, the list of cycles the sequencer must go through, then replays it
// cycle by cycle and compares stage and strobes.
module tb_hart_sequencer;
  import isa_types::*;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  opcode_t     opcode = OP;
  logic        mem_req, mem_we, mem_sel, mem_ack = 1'b0;
  logic        ir_load, rf_we, pc_we;
  stage_t      stage;
  logic        halted;
  logic [1:0]  fault;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_instret = '0;

  hart_sequencer #(
    .MEM_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_sel (mem_sel),
    .mem_ack (mem_ack),
    .ir_load (ir_load),
    .rf_we   (rf_we),
    .pc_we   (pc_we),
    .stage   (stage),
    .halted  (halted),
    .fault   (fault),
    .instret (instret)
  );

  always #5 clk = ~clk;

  // One expected cycle: the ack the bench drives and what the DUT must show.
  typedef struct {
    logic   ack;
    stage_t stg;
    logic   req, we, sel, ir, rf, pc;
  } step_t;

  step_t plan[$];

  function automatic void push(logic ack, stage_t stg, logic req, logic we,
                               logic sel, logic ir, logic rf, logic pc);
    step_t s;
    s.ack = ack; s.stg = stg; s.req = req; s.we = we;
    s.sel = sel; s.ir = ir;   s.rf = rf;   s.pc = pc;
    plan.push_back(s);
  endfunction

  // Reference model: an instruction is a fetch with fw waits, a decode
  // cycle, an execute cycle, an optional memory access with mw waits and an
  // optional writeback. Stray acks are thrown into the non-memory cycles.
  function automatic void build_plan(opcode_t op, int fw, int mw);
    logic is_mem, is_store, is_branch;
    is_store  = (op == STORE);
    is_mem    = (op == LOAD) || is_store;
    is_branch = (op == BRANCH);
    plan.delete();
    for (int i = 0; i < fw; i++) push(1'b0, FETCH, 1, 0, 0, 0, 0, 0);
    push(1'b1, FETCH, 1, 0, 0, 1, 0, 0);
    push(1'($urandom_range(0, 1)), DECODE, 0, 0, 0, 0, 0, 0);
    push(1'($urandom_range(0, 1)), EXECUTE, 0, 0, 0, 0, 0, is_branch);
    if (is_mem) begin
      for (int i = 0; i < mw; i++) push(1'b0, MEM, 1, is_store, 1, 0, 0, 0);
      push(1'b1, MEM, 1, is_store, 1, 0, 0, is_store);
    end
    if (!is_branch && !is_store)
      push(1'($urandom_range(0, 1)), WRITEBACK, 0, 0, 0, 0, 1, 1);
  endfunction

  // Entered between a posedge and the following negedge of a fresh FETCH
  // cycle; returns at the same point of the next instruction's first cycle.
  task automatic run_instr(opcode_t op, int fw, int mw, string name);
    logic [6:0] junk;
    build_plan(op, fw, mw);
    foreach (plan[k]) begin
      @(negedge clk);
      mem_ack = plan[k].ack;
      junk    = 7'($urandom);
      opcode  = (plan[k].stg == EXECUTE || plan[k].stg == MEM) ? op : opcode_t'(junk);
      #1;
      checks++;
      if ({stage, mem_req, mem_we, mem_sel, ir_load, rf_we, pc_we} !==
          {plan[k].stg, plan[k].req, plan[k].we, plan[k].sel, plan[k].ir, plan[k].rf, plan[k].pc}) begin
        errors++;
        $display("FAIL %s step %0d: got stage=%0d req=%b we=%b sel=%b ir=%b rf=%b pc=%b, expected stage=%0d req=%b we=%b sel=%b ir=%b rf=%b pc=%b",
                 name, k, stage, mem_req, mem_we, mem_sel, ir_load, rf_we, pc_we,
                 plan[k].stg, plan[k].req, plan[k].we, plan[k].sel, plan[k].ir, plan[k].rf, plan[k].pc);
      end
    end
    exp_instret = exp_instret + 64'd1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++;
    if (stage !== FETCH || instret !== exp_instret || fault !== FAULT_NONE) begin
      errors++;
      $display("FAIL %s retire: got stage=%0d instret=%0h fault=%0d, expected stage=%0d instret=%0h fault=0",
               name, stage, instret, fault, FETCH, exp_instret);
    end
  endtask

  // Leaves the DUT in its first active FETCH cycle, just after the edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (stage !== FETCH || mem_req !== 1'b0 || instret !== 64'd0 || fault !== 2'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got stage=%0d req=%b instret=%0h fault=%0d halted=%b, expected 0 0 0 0 0",
               stage, mem_req, instret, fault, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_req: got %b before first edge, expected 0", mem_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || stage !== FETCH) begin
      errors++;
      $display("FAIL first_edge_req: got req=%b stage=%0d, expected req=1 stage=%0d", mem_req, stage, FETCH);
    end
    exp_instret = '0;
  endtask

  task automatic test_addi();
    run_instr(OP_IMM, 1, 0, "addi");
    checks++;
    if (instret !== 64'd1) begin
      errors++;
      $display("FAIL addi_instret: got %0d, expected 1", instret);
    end
  endtask

  task automatic test_load_store();
    run_instr(LOAD, int'($urandom_range(0, 3)), 3, "load");
    run_instr(STORE, int'($urandom_range(0, 3)), 3, "store");
    run_instr(BRANCH, int'($urandom_range(0, 3)), 0, "branch");
  endtask

  task automatic test_ack_at_limit();
    run_instr(OP, int'(TB_TIMEOUT), 0, "fetch_ack_at_limit");
    run_instr(STORE, 0, int'(TB_TIMEOUT), "mem_ack_at_limit");
  endtask

  task automatic test_random();
    opcode_t legal[9] = '{LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH};
    for (int n = 0; n < 40; n++) begin
      run_instr(legal[$urandom_range(0, 8)], int'($urandom_range(0, TB_TIMEOUT)),
                int'($urandom_range(0, TB_TIMEOUT)), "random");
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad = 7'b0000000;
    logic [6:0] junk;
    do_reset();
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk); opcode = opcode_t'(bad);
    @(posedge clk);
    #1;
    checks++;
    if (stage !== HALT || fault !== FAULT_ILLEGAL || halted !== 1'b1) begin
      errors++;
      $display("FAIL illegal_halt: got stage=%0d fault=%0d halted=%b, expected stage=%0d fault=1 halted=1",
               stage, fault, halted, HALT);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      junk    = 7'($urandom);
      opcode  = opcode_t'(junk);
      #1;
      checks++;
      if (stage !== HALT || fault !== FAULT_ILLEGAL || halted !== 1'b1 || instret !== 64'd0 ||
          {mem_req, mem_we, ir_load, rf_we, pc_we} !== 5'b0) begin
        errors++;
        $display("FAIL illegal_absorb %0d: got stage=%0d fault=%0d halted=%b instret=%0d strobes=%b, expected HALT 1 1 0 00000",
                 i, stage, fault, halted, instret, {mem_req, mem_we, ir_load, rf_we, pc_we});
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i <= int'(TB_TIMEOUT); i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      checks++;
      if (stage !== FETCH || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL fetch_wait %0d: got stage=%0d req=%b, expected stage=%0d req=1", i, stage, mem_req, FETCH);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (stage !== HALT || fault !== FAULT_BUS || halted !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_timeout: got stage=%0d fault=%0d halted=%b req=%b, expected stage=%0d fault=2 halted=1 req=0",
               stage, fault, halted, mem_req, HALT);
    end
    // Same limit on the data side.
    do_reset();
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk); opcode = LOAD;
    repeat (TB_TIMEOUT + 1) @(negedge clk);
    #1;
    checks++;
    if (stage !== MEM || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_last: got stage=%0d req=%b, expected stage=%0d req=1", stage, mem_req, MEM);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stage !== HALT || fault !== FAULT_BUS || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mem_timeout: got stage=%0d fault=%0d req=%b, expected stage=%0d fault=2 req=0",
               stage, fault, mem_req, HALT);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run_instr(OP, 0, 0, "pre_reset");
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk); opcode = STORE;
    @(negedge clk);
    #1;
    checks++;
    if (stage !== MEM || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL store_mem_pre: got stage=%0d we=%b, expected stage=%0d we=1", stage, mem_we, MEM);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage !== FETCH || instret !== 64'd0 || halted !== 1'b0 || fault !== 2'd0 ||
        {mem_req, mem_we, mem_sel, ir_load, rf_we, pc_we} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got stage=%0d instret=%0d strobes=%b, expected stage=%0d instret=0 strobes=000000",
               stage, instret, {mem_req, mem_we, mem_sel, ir_load, rf_we, pc_we}, FETCH);
    end
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0 || stage !== FETCH) begin
      errors++;
      $display("FAIL reset_hold: got we=%b req=%b stage=%0d, expected 0 0 %0d", mem_we, mem_req, stage, FETCH);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    exp_instret = '0;
    checks++;
    if (stage !== FETCH || mem_req !== 1'b1 || mem_we !== 1'b0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_resume: got stage=%0d req=%b we=%b instret=%0d, expected %0d 1 0 0",
               stage, mem_req, mem_we, instret, FETCH);
    end
  endtask

  task automatic test_instret_wrap();
    do_reset();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    checks++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL instret_preset: got %0h, expected ffffffffffffffff", instret);
    end
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    run_instr(OP_IMM, 2, 0, "wrap");
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL instret_wrap: got %0h, expected 0", instret);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_ack_at_limit();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hart_sequencer.md
HART_SEQUENCER -- requirements
Module: hart_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum wait cycles for mem_ack before a bus fault.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  opcode_t  opcode of the latched instruction, from the instruction decoder.
REQ-005 mem_req  output  1  request to the single shared memory port.
REQ-006 mem_we  output  1  write strobe, qualified by mem_req.
REQ-007 mem_sel  output  1  address mux: 0 = PC (fetch), 1 = ALU result (data).
REQ-008 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-009 ir_load  output  1  latch memory read data into the instruction register.
REQ-010 rf_we  output  1  register file write enable.
REQ-011 pc_we  output  1  PC update enable.
REQ-012 stage  output  stage_t  current state, for debug.
REQ-013 halted  output  1  sticky halt flag.
REQ-014 fault  output  2  halt cause: 0 none, 1 illegal opcode, 2 bus timeout.
REQ-015 instret  output  64  retired-instruction count.

Function
REQ-016 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-017 FETCH: mem_req=1, mem_sel=0, mem_we=0.
- mem_ack -> ir_load=1 that cycle; next state DECODE.
- No ack -> remain in FETCH.
REQ-018 DECODE: no strobes; always go to EXECUTE (allows one cycle for the decoder and register reads).
REQ-019 EXECUTE transitions by opcode:
- LOAD, STORE -> MEM.
- OP, OP_IMM, LUI, AUIPC, JAL, JALR -> WRITEBACK.
- BRANCH -> pc_we=1, then FETCH.
- Any other opcode -> HALT with fault=1.
REQ-020 MEM: mem_req=1, mem_sel=1, mem_we=1 only for STORE.
- On mem_ack: LOAD -> WRITEBACK; STORE -> pc_we=1, then FETCH.
REQ-021 WRITEBACK: rf_we=1 and pc_we=1 for exactly one cycle, then FETCH.
REQ-022 instret increments by 1 on each cycle in which pc_we=1 outside HALT. It wraps modulo 2^64.
REQ-023 Wait counter:
- Clears on entry to FETCH or MEM and on mem_ack.
- Increments on each cycle of mem_req=1 without mem_ack.
- Count reaching MEM_TIMEOUT without ack -> HALT with fault=2; mem_req drops the next cycle.
REQ-024 mem_ack outside FETCH or MEM is ignored; no state or counter change.
REQ-025 mem_ack on the same cycle the counter reaches MEM_TIMEOUT: the ack wins, no fault.
REQ-026 HALT is absorbing until reset.
- All strobes are 0; halted=1; fault holds its value.
REQ-027 All strobes (mem_req, mem_we, ir_load, rf_we, pc_we) are Moore/Mealy decodes of the registered state, opcode and mem_ack. No strobe is registered a second time.
REQ-028 Opcode is sampled only in EXECUTE and MEM. Changes in other states have no effect.

Reset
REQ-029 rst_n low immediately forces the following, regardless of the clock:
- stage=FETCH.
- Wait counter=0, instret=0, fault=0, halted=0.
REQ-030 While rst_n is low, all strobes including mem_req are 0.
REQ-031 Reset asserted mid-transaction abandons it; no write strobe completes.
REQ-032 After rst_n deasserts, mem_req rises on the first clk edge.

Structure
REQ-033 The isa_types package holds:
- stage_t (enum, 3 bits) and the fault encoding constants.
- opcode_t and its existing enumerators.
REQ-034 A sub-module mem_wait_timer (counter, clear, timeout output) is natural; all other logic stays in one always_ff state register plus one always_comb decode.

Verification
REQ-035 ADDI test: OP_IMM, ack on cycle 2 of FETCH -> ir_load cycle 2, then DECODE, EXECUTE, WRITEBACK (rf_we=pc_we=1), back to FETCH; instret=1.
REQ-036 Load/store test: LOAD with MEM ack after 3 waits -> mem_sel=1, mem_we=0, then WRITEBACK. STORE -> mem_we=1, no rf_we, instret increments.
REQ-037 Illegal opcode 7'b0000000 in EXECUTE -> HALT, fault=1, halted=1. Later mem_ack pulses cause no change.
REQ-038 Timeout test with MEM_TIMEOUT=4 and no ack in FETCH -> HALT with fault=2 after 4 wait cycles. Ack coinciding with count 4 -> no fault.
REQ-039 rst_n pulsed low mid-MEM for a STORE -> outputs zero asynchronously, state FETCH, instret=0, and no extra mem_we.
REQ-040 instret preset near 2^64-1 via force, then one retirement -> instret wraps to 0.
